// File: rtl/tile_gfx_pkg.sv
// Shared geometry, types and address helpers for the tile line renderer.
// No ports; imported by tile_line_renderer and line_buffer_2bank.
package tile_gfx_pkg;

    localparam int H_TILES     = 20;
    localparam int V_TILES     = 15;
    localparam int TILE_PX     = 32;
    localparam int PX_PER_WORD = 8;
    localparam int ACTIVE_W    = H_TILES * TILE_PX;
    localparam int ACTIVE_H    = V_TILES * TILE_PX;

    localparam int WORDS_PER_TILE_ROW = TILE_PX / PX_PER_WORD;
    localparam int WORDS_PER_TILE     = TILE_PX * WORDS_PER_TILE_ROW;
    localparam int LB_WORDS           = ACTIVE_W / PX_PER_WORD;

    typedef logic [3:0]  tile_idx_t;
    typedef logic [2:0]  pal_idx_t;
    typedef logic [23:0] rgb_t;
    typedef logic [23:0] lb_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TB_REQ,
        ST_TB_CAP,
        ST_GFX0,
        ST_GFX1,
        ST_GFX2,
        ST_GFX3,
        ST_DRAIN
    } rndr_state_t;

    function automatic logic [8:0] tb_addr_of(input logic [8:0] line, input logic [4:0] col);
        return 9'((int'(line) / TILE_PX) * H_TILES + int'(col));
    endfunction

    function automatic logic [10:0] tg_addr_of(input tile_idx_t tile, input logic [8:0] line,
                                               input logic [1:0] w);
        return 11'(int'(tile) * WORDS_PER_TILE
                   + (int'(line) % TILE_PX) * WORDS_PER_TILE_ROW + int'(w));
    endfunction

endpackage

// File: rtl/line_buffer_2bank.sv
// Ping-pong scanline storage: two banks of LB_WORDS words, 8 x 3-bit palette
// indices per word.
// Ports: clk_i, reset_i (sync, active-low; clears only the read register),
//        wr_en_i/wr_bank_i/wr_word_i/wr_data_i (write port),
//        rd_bank_i/rd_word_i -> rd_data_o (registered read, 1 cycle).
module line_buffer_2bank
    import tile_gfx_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       wr_en_i,
    input  logic       wr_bank_i,
    input  logic [6:0] wr_word_i,
    input  lb_word_t   wr_data_i,
    input  logic       rd_bank_i,
    input  logic [6:0] rd_word_i,
    output lb_word_t   rd_data_o
);

    lb_word_t   mem_q [2*LB_WORDS];
    lb_word_t   rd_data_q;
    logic [7:0] wr_idx;
    logic [7:0] rd_idx;

    assign wr_idx = (wr_bank_i ? 8'(LB_WORDS) : 8'd0) + {1'b0, wr_word_i};
    assign rd_idx = (rd_bank_i ? 8'(LB_WORDS) : 8'd0) + {1'b0, rd_word_i};

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

    // Words past the visible line (hblank) read as zero rather than aliasing
    // into the other bank.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rd_data_q <= '0;
        end else if (rd_word_i < 7'(LB_WORDS)) begin
            rd_data_q <= mem_q[rd_idx];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tile_line_renderer.sv
// Fetches one scanline of tile pixels into the fill bank of a ping-pong line
// buffer while streaming the display bank to RGB through the palette.
// Ports: clk_i, reset_i (sync, active-low), line_start_i/render_line_i (fill
//        request), hcount_i (display x), tb_addr_o/tb_rdata_i (tile map),
//        tg_addr_o/tg_rdata_i (tile graphics), pal_addr_o/pal_rdata_i
//        (palette), rgb_o, fill_done_o, overrun_o.
//
// state     | meaning
// IDLE      | no fill in progress
// TB_REQ    | tile map address for column col on the bus
// TB_CAP    | tile index returns; first graphics address computed
// GFX0..3   | graphics word w on the bus; previous word written to buffer
// DRAIN     | last graphics word of the line written
module tile_line_renderer
    import tile_gfx_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        line_start_i,
    input  logic [8:0]  render_line_i,
    input  logic [9:0]  hcount_i,
    output logic [8:0]  tb_addr_o,
    input  logic [31:0] tb_rdata_i,
    output logic [10:0] tg_addr_o,
    input  logic [31:0] tg_rdata_i,
    output pal_idx_t    pal_addr_o,
    input  rgb_t        pal_rdata_i,
    output rgb_t        rgb_o,
    output logic        fill_done_o,
    output logic        overrun_o
);

    rndr_state_t state_q, state_d;
    logic [4:0]  col_q, col_d;
    logic [8:0]  line_q, line_d;
    tile_idx_t   tile_q, tile_d;
    logic        disp_bank_q, disp_bank_d;
    logic [8:0]  tb_addr_q, tb_addr_d;
    logic [10:0] tg_addr_q, tg_addr_d;
    logic        wr_en_q, wr_en_d;
    logic [6:0]  wr_word_q, wr_word_d;
    logic        fill_done_q, fill_done_d;
    logic        overrun_q, overrun_d;

    pal_idx_t    px_sel_q;
    logic        vld1_q, vld2_q;
    rgb_t        rgb_q;

    lb_word_t    wr_data;
    lb_word_t    rd_data;
    logic        unused_bits;

    // Bit 3 of every nibble and the upper tile map bits carry nothing.
    assign unused_bits = ^{tb_rdata_i[31:4], tg_rdata_i[31], tg_rdata_i[27], tg_rdata_i[23],
                           tg_rdata_i[19], tg_rdata_i[15], tg_rdata_i[11], tg_rdata_i[7],
                           tg_rdata_i[3]};

    always_comb begin
        wr_data = '0;
        for (int k = 0; k < PX_PER_WORD; k++) begin
            wr_data[k*3 +: 3] = tg_rdata_i[k*4 +: 3];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            line_q      <= '0;
            tile_q      <= '0;
            disp_bank_q <= 1'b0;
            tb_addr_q   <= '0;
            tg_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_word_q   <= '0;
            fill_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            line_q      <= line_d;
            tile_q      <= tile_d;
            disp_bank_q <= disp_bank_d;
            tb_addr_q   <= tb_addr_d;
            tg_addr_q   <= tg_addr_d;
            wr_en_q     <= wr_en_d;
            wr_word_q   <= wr_word_d;
            fill_done_q <= fill_done_d;
            overrun_q   <= overrun_d;
        end
    end

    // A new line_start always wins: it swaps banks and drops any graphics
    // word still in flight so the abandoned fill cannot touch the new bank.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        line_d      = line_q;
        tile_d      = tile_q;
        disp_bank_d = disp_bank_q;
        tb_addr_d   = tb_addr_q;
        tg_addr_d   = tg_addr_q;
        wr_en_d     = 1'b0;
        wr_word_d   = wr_word_q;
        fill_done_d = 1'b0;
        overrun_d   = 1'b0;
        if (line_start_i) begin
            disp_bank_d = ~disp_bank_q;
            line_d      = render_line_i;
            col_d       = '0;
            overrun_d   = (state_q != ST_IDLE);
            if (render_line_i >= 9'(ACTIVE_H)) begin
                state_d     = ST_IDLE;
                fill_done_d = 1'b1;
            end else begin
                state_d   = ST_TB_REQ;
                tb_addr_d = tb_addr_of(render_line_i, 5'd0);
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_TB_REQ: begin
                    state_d = ST_TB_CAP;
                end
                ST_TB_CAP: begin
                    tile_d    = tb_rdata_i[3:0];
                    tg_addr_d = tg_addr_of(tb_rdata_i[3:0], line_q, 2'd0);
                    state_d   = ST_GFX0;
                end
                ST_GFX0: begin
                    wr_en_d   = 1'b1;
                    wr_word_d = {col_q, 2'd0};
                    tg_addr_d = tg_addr_of(tile_q, line_q, 2'd1);
                    state_d   = ST_GFX1;
                end
                ST_GFX1: begin
                    wr_en_d   = 1'b1;
                    wr_word_d = {col_q, 2'd1};
                    tg_addr_d = tg_addr_of(tile_q, line_q, 2'd2);
                    state_d   = ST_GFX2;
                end
                ST_GFX2: begin
                    wr_en_d   = 1'b1;
                    wr_word_d = {col_q, 2'd2};
                    tg_addr_d = tg_addr_of(tile_q, line_q, 2'd3);
                    state_d   = ST_GFX3;
                end
                ST_GFX3: begin
                    wr_en_d   = 1'b1;
                    wr_word_d = {col_q, 2'd3};
                    if (col_q == 5'(H_TILES - 1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        col_d     = col_q + 5'd1;
                        tb_addr_d = tb_addr_of(line_q, col_q + 5'd1);
                        state_d   = ST_TB_REQ;
                    end
                end
                ST_DRAIN: begin
                    state_d     = ST_IDLE;
                    fill_done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // wr_en_q marks the cycle in which the word addressed one cycle earlier
    // is on tg_rdata_i.
    line_buffer_2bank u_lb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .wr_en_i   (wr_en_q),
        .wr_bank_i (~disp_bank_q),
        .wr_word_i (wr_word_q),
        .wr_data_i (wr_data),
        .rd_bank_i (disp_bank_q),
        .rd_word_i (hcount_i[9:3]),
        .rd_data_o (rd_data)
    );

    // Display pipeline: buffer read (N+1), palette read (N+2), rgb (N+3).
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            px_sel_q <= '0;
            vld1_q   <= 1'b0;
            vld2_q   <= 1'b0;
            rgb_q    <= '0;
        end else begin
            px_sel_q <= hcount_i[2:0];
            vld1_q   <= (hcount_i < 10'(ACTIVE_W));
            vld2_q   <= vld1_q;
            rgb_q    <= vld2_q ? pal_rdata_i : '0;
        end
    end

    assign pal_addr_o  = rd_data[int'(px_sel_q)*3 +: 3];
    assign tb_addr_o   = tb_addr_q;
    assign tg_addr_o   = tg_addr_q;
    assign rgb_o       = rgb_q;
    assign fill_done_o = fill_done_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_tile_line_renderer.sv
module tb_tile_line_renderer;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        line_start_i;
    logic [8:0]  render_line_i;
    logic [9:0]  hcount_i;
    logic [8:0]  tb_addr_o;
    logic [31:0] tb_rdata_i;
    logic [10:0] tg_addr_o;
    logic [31:0] tg_rdata_i;
    logic [2:0]  pal_addr_o;
    logic [23:0] pal_rdata_i;
    logic [23:0] rgb_o;
    logic        fill_done_o;
    logic        overrun_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] tb_mem [0:511];
    logic [31:0] tg_mem [0:2047];
    logic [23:0] pal    [0:7];

    logic [9:0]  hq[$];
    logic [23:0] eq[$];

    typedef struct {
        logic [9:0]  hc;
        logic [23:0] exp_rgb;
    } pix_vec_t;

    pix_vec_t vecs [14];

    always #5 clk_i = ~clk_i;

    tile_line_renderer dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .line_start_i  (line_start_i),
        .render_line_i (render_line_i),
        .hcount_i      (hcount_i),
        .tb_addr_o     (tb_addr_o),
        .tb_rdata_i    (tb_rdata_i),
        .tg_addr_o     (tg_addr_o),
        .tg_rdata_i    (tg_rdata_i),
        .pal_addr_o    (pal_addr_o),
        .pal_rdata_i   (pal_rdata_i),
        .rgb_o         (rgb_o),
        .fill_done_o   (fill_done_o),
        .overrun_o     (overrun_o)
    );

    // Synchronous-read memory models.
    always @(posedge clk_i) begin
        tb_rdata_i  <= tb_mem[tb_addr_o];
        tg_rdata_i  <= tg_mem[tg_addr_o];
        pal_rdata_i <= pal[pal_addr_o];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int tg_model(input int line, input int col, input int w);
        logic [31:0] ent;
        ent = tb_mem[(line / 32) * 20 + col];
        return int'(ent[3:0]) * 128 + (line % 32) * 4 + w;
    endfunction

    function automatic logic [23:0] rgb_model(input int line, input int x);
        logic [31:0] ent;
        logic [31:0] word;
        int          tile;
        if (x >= 640) return 24'h0;
        ent  = tb_mem[(line / 32) * 20 + x / 32];
        tile = int'(ent[3:0]);
        word = tg_mem[tile * 128 + (line % 32) * 4 + (x % 32) / 8];
        return pal[(word >> (4 * (x % 8))) & 32'h7];
    endfunction

    // Pulses line_start in one cycle; returns sampling the following cycle.
    task automatic start_line(input int line);
        @(negedge clk_i);
        line_start_i  = 1'b1;
        render_line_i = 9'(line);
        @(negedge clk_i);
        line_start_i  = 1'b0;
    endtask

    // Called in cycle 1 after a line_start; watches until fill_done.
    task automatic watch_fill(input int line, input bit chk_addr, input int exp_ovr,
                              input int exp_done, input string tag);
        int c;
        int ovr;
        int base;
        c    = 1;
        ovr  = 0;
        base = (line / 32) * 20;
        while (c < 300) begin
            if (overrun_o === 1'b1) ovr++;
            if (chk_addr && c <= 120) begin
                int ph;
                int col;
                ph  = (c - 1) % 6;
                col = (c - 1) / 6;
                if (ph == 0)
                    chk({tag, " tb_addr"}, 32'(tb_addr_o), 32'(base + col));
                else if (ph >= 2)
                    chk({tag, " tg_addr"}, 32'(tg_addr_o), 32'(tg_model(line, col, ph - 2)));
            end
            if (fill_done_o === 1'b1) break;
            @(negedge clk_i);
            c++;
        end
        chk({tag, " fill_done cycle"}, 32'(c), 32'(exp_done));
        chk({tag, " overrun count"}, 32'(ovr), 32'(exp_ovr));
        @(negedge clk_i);
        chk({tag, " fill_done width"}, 32'(fill_done_o), 32'd0);
    endtask

    task automatic run_stream(input string name);
        int n;
        n = hq.size();
        for (int i = 0; i < n + 3; i++) begin
            @(negedge clk_i);
            if (i >= 3) chk(name, 32'(rgb_o), 32'(eq[i-3]));
            hcount_i = (i < n) ? hq[i] : 10'd700;
        end
        hq.delete();
        eq.delete();
    endtask

    initial begin
        int saved;
        int cnt_done;
        int cnt_addr;

        vecs[0]  = '{10'd32,  24'h000000};
        vecs[1]  = '{10'd33,  24'h111111};
        vecs[2]  = '{10'd34,  24'h222222};
        vecs[3]  = '{10'd35,  24'h333333};
        vecs[4]  = '{10'd36,  24'h444444};
        vecs[5]  = '{10'd37,  24'h555555};
        vecs[6]  = '{10'd38,  24'h666666};
        vecs[7]  = '{10'd39,  24'h777777};
        vecs[8]  = '{10'd64,  24'h777777};
        vecs[9]  = '{10'd71,  24'h777777};
        vecs[10] = '{10'd95,  24'h777777};
        vecs[11] = '{10'd640, 24'h000000};
        vecs[12] = '{10'd700, 24'h000000};
        vecs[13] = '{10'd799, 24'h000000};

        for (int i = 0; i < 512; i++) tb_mem[i] = $urandom;
        for (int i = 0; i < 2048; i++) tg_mem[i] = $urandom;
        for (int k = 0; k < 8; k++) pal[k] = 24'(k * 24'h111111);
        tb_mem[21] = 32'h5;
        tb_mem[22] = 32'hABCD_0006;
        tg_mem[644] = 32'h7654_3210;
        for (int w = 0; w < 4; w++) tg_mem[6*128 + 4 + w] = 32'hFFFF_FFFF;

        reset_i       = 1'b0;
        line_start_i  = 1'b0;
        render_line_i = '0;
        hcount_i      = 10'd700;

        // Reset state and quiet idle.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset tb_addr", 32'(tb_addr_o), 0);
        chk("reset tg_addr", 32'(tg_addr_o), 0);
        chk("reset pal_addr", 32'(pal_addr_o), 0);
        chk("reset rgb", 32'(rgb_o), 0);
        chk("reset fill_done", 32'(fill_done_o), 0);
        chk("reset overrun", 32'(overrun_o), 0);
        reset_i  = 1'b1;
        cnt_done = 0;
        cnt_addr = 0;
        repeat (200) begin
            @(negedge clk_i);
            if (fill_done_o === 1'b1) cnt_done++;
            if (tb_addr_o !== 9'd0 || tg_addr_o !== 11'd0) cnt_addr++;
        end
        chk("idle fill_done pulses", 32'(cnt_done), 0);
        chk("idle addr activity", 32'(cnt_addr), 0);
        chk("idle rgb", 32'(rgb_o), 0);

        // Address sequence for line 33.
        start_line(33);
        watch_fill(33, 1'b1, 0, 122, "line33");

        // Pixel path: show line 33 while line 34 fills.
        start_line(34);
        for (int i = 0; i < 14; i++) begin
            hq.push_back(vecs[i].hc);
            eq.push_back(vecs[i].exp_rgb);
        end
        run_stream("pixel table");
        repeat (140) @(negedge clk_i);

        // Overrun: second pulse in cycle 50 of a fill.
        start_line(33);
        repeat (48) @(negedge clk_i);
        start_line(100);
        chk("overrun pulse", 32'(overrun_o), 1);
        chk("overrun restart tb_addr", 32'(tb_addr_o), 60);
        watch_fill(100, 1'b1, 1, 122, "overrun refill");

        // Out-of-range line: no reads, immediate fill_done.
        saved = int'(tb_addr_o);
        start_line(480);
        watch_fill(480, 1'b0, 0, 1, "line480");
        repeat (5) @(negedge clk_i);
        chk("line480 tb_addr held", 32'(tb_addr_o), 32'(saved));

        // Randomized lines and pixels against the model.
        for (int it = 0; it < 4; it++) begin
            int l1;
            int l2;
            l1 = int'($urandom_range(0, 479));
            l2 = int'($urandom_range(0, 599));
            start_line(l1);
            watch_fill(l1, 1'b1, 0, 122, "random fill");
            start_line(l2);
            for (int p = 0; p < 120; p++) begin
                int x;
                x = int'($urandom_range(0, 799));
                hq.push_back(10'(x));
                eq.push_back(rgb_model(l1, x));
            end
            run_stream("random pixel");
            repeat (140) @(negedge clk_i);
        end

        // Reset in the middle of a fill.
        start_line(200);
        repeat (30) @(negedge clk_i);
        reset_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("midreset tb_addr", 32'(tb_addr_o), 0);
        chk("midreset tg_addr", 32'(tg_addr_o), 0);
        chk("midreset fill_done", 32'(fill_done_o), 0);
        reset_i  = 1'b1;
        cnt_done = 0;
        cnt_addr = 0;
        repeat (200) begin
            @(negedge clk_i);
            if (fill_done_o === 1'b1) cnt_done++;
            if (tb_addr_o !== 9'd0) cnt_addr++;
        end
        chk("midreset fill_done pulses", 32'(cnt_done), 0);
        chk("midreset addr activity", 32'(cnt_addr), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_line_renderer.md
Name: tile_line_renderer

Overview:
- Downstream consumer of tile_buffer, tile_graphics and color_palettes; sits between those memories and the VGA output.
- On each line_start it fetches one scanline of tile pixels into one bank of a ping-pong line buffer.
- While that fill runs, it streams the other bank to RGB through the palette, indexed by the display hcount.

Parameters:
- H_TILES, 20, tile columns per line.
- V_TILES, 15, tile rows per frame.
- TILE_PX, 32, tile edge in pixels.
- PX_PER_WORD, 8, 4-bit pixels per 32-bit tile_graphics word.
- ACTIVE_W, 640, visible pixels per line.
- ACTIVE_H, 480, visible lines.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- line_start  in  1  single-cycle pulse: swap banks, begin fill
- render_line  in  9  line to fill (0..479), sampled with line_start
- hcount  in  10  display pixel x (0..799)
- tb_addr  out  9  tile_buffer read address
- tb_rdata  in  32  tile_buffer data, 1-cycle sync read; [3:0] = tile index
- tg_addr  out  11  tile_graphics read address
- tg_rdata  in  32  tile_graphics data, 1-cycle sync read; nibble k = pixel k, bits [3+4k:4k], bit 3 of nibble ignored
- pal_addr  out  3  color_palettes read address
- pal_rdata  in  24  palette RGB, 1-cycle sync read
- rgb  out  24  pixel colour
- fill_done  out  1  pulse: fill bank complete
- overrun  out  1  pulse: line_start arrived during a fill

Behaviour:
- Reset (reset==0 at an edge):
  - FSM=IDLE; display bank=0, fill bank=1.
  - tb_addr, tg_addr, pal_addr, rgb, fill_done, overrun all 0.
  - Line buffer contents are not cleared.
- Line buffer:
  - 2 banks × 80 words × 24 bits; each word holds 8 pixels × 3-bit palette index.
  - The renderer has priority on tile_buffer and tile_graphics; the top level drives their rw to read whenever the renderer FSM is not IDLE.
- Addressing:
  - tb_addr = (render_line/32)*20 + col.
  - tg_addr = tile_idx*128 + (render_line%32)*4 + w, with w in 0..3.
- FSM states: IDLE, TB_REQ, TB_CAP, GFX0, GFX1, GFX2, GFX3, DRAIN.
  - IDLE --line_start--> TB_REQ (col=0); latch render_line; swap banks.
  - TB_REQ: drive tb_addr.
  - TB_CAP: latch tb_rdata[3:0] as tile_idx.
  - GFXw: drive tg_addr. The returned word is written one cycle later to line-buffer word col*4+w. Writes overlap the next state.
  - After GFX3: col<19 → TB_REQ with col+1; col==19 → DRAIN.
  - DRAIN: last write lands → IDLE, with fill_done high for exactly one cycle.
- Timing: line_start in cycle 0 → fill_done high in cycle 122 (20 tiles × 6 states + DRAIN + 1).
- render_line >= 480: banks swap, no memory reads, fill bank unchanged, fill_done pulses in cycle 1.
- line_start while not IDLE:
  - overrun pulses the next cycle.
  - The current fill is abandoned and the banks swap; the partial bank becomes the display bank.
  - The fill restarts at col=0 with the new render_line.
- Display pipeline (latency 3):
  - Cycle N: hcount presented.
  - N+1: registered line-buffer read of word hcount[9:3] from the display bank; pal_addr = pixel hcount[2:0] of that word.
  - N+2: pal_rdata valid.
  - N+3: rgb registered.
  - hcount >= 640: a valid bit pipelined alongside forces rgb=0 at N+3.
- Reset mid-fill: abandons immediately; no fill_done is produced.

Decomposition:
- Package tile_gfx_pkg holds:
  - Geometry constants: H_TILES, V_TILES, TILE_PX, PX_PER_WORD, ACTIVE_W, ACTIVE_H.
  - WORDS_PER_TILE_ROW = 4 and WORDS_PER_TILE = 128.
  - The renderer FSM state enum, and the typedefs tile_idx_t (4b), pal_idx_t (3b), rgb_t (24b).
- One sub-module: line_buffer_2bank. It has a write port (bank, word, 24b data) and a registered read port (bank, word), and owns the ping-pong storage.

Test Plan:
- Reset: hold reset=0 for 3 cycles → all outputs 0; then with no line_start for 200 cycles, tb_addr and tg_addr stay 0 and fill_done never pulses.
- Address sequence: tile_buffer entry 21 = 5, line_start with render_line=33 → tb_addr 20, then 21 …; for col 1, tg_addr = 5*128+1*4+0..3 = 644..647; fill_done in cycle 122.
- Pixel path:
  - tile_graphics word 644 = 0x76543210, palette[k] = k*0x111111.
  - Fill line 33, then line_start again, then sweep hcount 32..39.
  - Expected: rgb 0x000000, 0x111111, …, 0x777777 at a 3-cycle lag.
- Nibble bit 3 ignored: word 0xFFFFFFFF → all 8 pixels use palette[7].
- Overrun: second line_start at cycle 50 of a fill → overrun high at cycle 51, tb_addr restarts at the new row base, fill_done at 122 cycles after the second pulse.
- Blanking: hcount 640..799 → rgb 0; render_line=480 → no tb_addr activity, fill_done in cycle 1.
